// File: rtl/sys_arr_row_skew.sv
// Row skew front-end for a systolic array.
// Each accepted row vector is screened for IEEE-754 single-precision specials
// and then fanned out so that lane i reaches array row i i+1 cycles after
// acceptance. The result is the diagonal wavefront that the array expects.

package sys_arr_row_skew_pkg;

    // Sticky screening flags: overflow = Inf/NaN seen, underflow = subnormal flushed
    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_t;

endpackage

module sys_arr_row_skew
    import sys_arr_row_skew_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*32-1:0]     in_data,
    input  logic                stall,
    input  logic                flush,
    output logic [N*32-1:0]     out_data,
    output logic [N-1:0]        out_valid,
    output logic                busy,
    output logic [CNT_W-1:0]    row_cnt,
    output err_t                err
);

    localparam int WORD_W = 32;

    // Subnormal: zero exponent with a nonzero mantissa
    function automatic logic is_subnormal(input logic [WORD_W-1:0] w);
        is_subnormal = (w[30:23] == 8'h00) && (w[22:0] != 23'd0);
    endfunction

    // Inf or NaN: all-ones exponent
    function automatic logic is_inf_nan(input logic [WORD_W-1:0] w);
        is_inf_nan = (w[30:23] == 8'hFF);
    endfunction

    // Flush subnormals to signed zero, canonicalise NaN, pass the rest untouched
    function automatic logic [WORD_W-1:0] screen_word(input logic [WORD_W-1:0] w);
        if (is_subnormal(w)) begin
            screen_word = {w[31], 31'd0};
        end else if (is_inf_nan(w) && (w[22:0] != 23'd0)) begin
            screen_word = 32'h7FC0_0000;
        end else begin
            screen_word = w;
        end
    endfunction

    logic         accept;
    logic [N-1:0] lane_ovf;
    logic [N-1:0] lane_udf;
    logic [N-1:0] lane_busy;

    // Flush takes priority over acceptance, and stall blocks it
    assign in_ready = !stall && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = |lane_busy;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [WORD_W-1:0] word_in;
        logic [WORD_W-1:0] data_p [0:i];
        logic [i:0]        vld_p;

        assign word_in     = in_data[i*WORD_W +: WORD_W];
        assign lane_ovf[i] = is_inf_nan(word_in);
        assign lane_udf[i] = is_subnormal(word_in);

        // Lane delay line of depth i+1: stage 0 loads the screened word or a bubble
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                vld_p <= '0;
                for (int k = 0; k <= i; k++) begin
                    data_p[k] <= '0;
                end
            end else if (flush) begin
                vld_p <= '0;
                for (int k = 0; k <= i; k++) begin
                    data_p[k] <= '0;
                end
            end else if (!stall) begin
                // stage 0 boundary: screening happens before the first register
                vld_p[0]  <= accept;
                data_p[0] <= accept ? screen_word(word_in) : '0;
                // stages 1..i boundary: plain shift toward the array
                for (int k = 1; k <= i; k++) begin
                    vld_p[k]  <= vld_p[k-1];
                    data_p[k] <= data_p[k-1];
                end
            end
        end

        assign out_data[i*WORD_W +: WORD_W] = data_p[i];
        assign out_valid[i]                 = vld_p[i];
        assign lane_busy[i]                 = |vld_p;
    end

    // Accepted-row counter, wrapping naturally at 2^CNT_W
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            row_cnt <= '0;
        end else if (flush) begin
            row_cnt <= '0;
        end else if (accept) begin
            row_cnt <= row_cnt + 1'b1;
        end
    end

    // Sticky error flags, set from any lane of an accepted row
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err <= '0;
        end else if (flush) begin
            err <= '0;
        end else if (accept) begin
            err.overflow  <= err.overflow  | (|lane_ovf);
            err.underflow <= err.underflow | (|lane_udf);
        end
    end

endmodule

// File: tb/tb_sys_arr_row_skew.sv
// Randomised and directed bench for sys_arr_row_skew against a history-window model.
module tb_sys_arr_row_skew;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct packed {
        logic           v;
        logic [N*W-1:0] d;
    } entry_t;

    logic           CLK = 1'b0;
    logic           nRST;
    logic           in_valid;
    logic           stall;
    logic           flush;
    logic [N*W-1:0] in_data;

    logic           in_ready,  in_ready_w;
    logic [N*W-1:0] out_data,  out_data_w;
    logic [N-1:0]   out_valid, out_valid_w;
    logic           busy,      busy_w;
    logic [15:0]    row_cnt;
    logic [3:0]     row_cnt_w;
    logic [1:0]     err,       err_w;

    sys_arr_row_skew #(.N(N), .CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .stall(stall), .flush(flush), .out_data(out_data),
        .out_valid(out_valid), .busy(busy), .row_cnt(row_cnt), .err(err)
    );

    sys_arr_row_skew #(.N(N), .CNT_W(4)) dut_w (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .stall(stall), .flush(flush), .out_data(out_data_w),
        .out_valid(out_valid_w), .busy(busy_w), .row_cnt(row_cnt_w), .err(err_w)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: hist[j] is what entered the skew j+1 shift-cycles ago
    entry_t      hist[$];
    int unsigned m_cnt;
    logic [1:0]  m_err;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] scr(input logic [W-1:0] w, output logic o, output logic u);
        int unsigned ex;
        int unsigned mn;
        ex = (w >> 23) & 32'hFF;
        mn = w & 32'h7F_FFFF;
        o = 1'b0;
        u = 1'b0;
        if (ex == 0 && mn != 0) begin
            u = 1'b1;
            return w & 32'h8000_0000;
        end
        if (ex == 255) begin
            o = 1'b1;
            return (mn != 0) ? 32'h7FC0_0000 : w;
        end
        return w;
    endfunction

    function automatic logic [W-1:0] rand_word();
        int k;
        logic s;
        k = $urandom_range(0, 99);
        s = 1'($urandom_range(0, 1));
        if (k < 4)       return {s, 8'h00, 23'($urandom_range(1, 23'h7F_FFFF))};
        else if (k < 7)  return {s, 8'hFF, 23'($urandom_range(1, 23'h7F_FFFF))};
        else if (k < 10) return {s, 8'hFF, 23'd0};
        else if (k < 14) return {s, 31'd0};
        else             return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    function automatic logic [N*W-1:0] rand_row();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = rand_word();
        return r;
    endfunction

    function automatic logic [N*W-1:0] normal_row();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
        return r;
    endfunction

    task automatic model_clear();
        entry_t e;
        e = '0;
        hist.delete();
        for (int i = 0; i < N; i++) hist.push_back(e);
        m_cnt = 0;
        m_err = 2'b00;
    endtask

    task automatic check_all();
        logic any;
        any = 1'b0;
        chk("in_ready", in_ready, !stall && !flush);
        chk("in_ready_w", in_ready_w, !stall && !flush);
        for (int i = 0; i < N; i++) begin
            any = any | hist[i].v;
            chk($sformatf("vld%0d", i), out_valid[i], hist[i].v);
            chk($sformatf("data%0d", i), out_data[i*W +: W], hist[i].d[i*W +: W]);
            chk($sformatf("vld_w%0d", i), out_valid_w[i], hist[i].v);
            chk($sformatf("data_w%0d", i), out_data_w[i*W +: W], hist[i].d[i*W +: W]);
        end
        chk("busy", busy, any);
        chk("busy_w", busy_w, any);
        chk("row_cnt", row_cnt, m_cnt & 32'hFFFF);
        chk("row_cnt_w", row_cnt_w, m_cnt & 32'hF);
        chk("err", err, m_err);
        chk("err_w", err_w, m_err);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"}, out_data, '0);
        chk({tag, "_vld"}, out_valid, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_cnt"}, row_cnt, '0);
        chk({tag, "_err"}, err, '0);
        chk({tag, "_cnt_w"}, row_cnt_w, '0);
        chk({tag, "_rdy"}, in_ready, !stall && !flush);
    endtask

    // One clock: model consumes the inputs presented before the edge, then outputs are checked
    task automatic tick();
        logic acc;
        logic o;
        logic u;
        entry_t e;
        acc = in_valid && !stall && !flush;
        e = '0;
        if (acc) begin
            e.v = 1'b1;
            for (int i = 0; i < N; i++) begin
                e.d[i*W +: W] = scr(in_data[i*W +: W], o, u);
                m_err[1] = m_err[1] | o;
                m_err[0] = m_err[0] | u;
            end
        end
        @(posedge CLK);
        if (flush) begin
            model_clear();
        end else if (!stall) begin
            if (acc) m_cnt++;
            hist.push_front(e);
            void'(hist.pop_back());
        end
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges; called just after a rising edge
    task automatic reset_pulse(input string tag);
        #3;
        nRST = 1'b0;
        #1;
        check_zero({tag, "_async"});
        model_clear();
        @(posedge CLK);
        #1;
        check_zero({tag, "_held"});
        nRST = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        nRST = 1'b1;
        idle();
        model_clear();
        @(posedge CLK);
        #1;

        // Single row 1.0 / 2.0 / 3.0 / 4.0 walks the diagonal
        reset_pulse("rst0");
        in_valid = 1'b1;
        in_data  = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
        tick();
        in_valid = 1'b0;
        chk("diag_vld1", out_valid, 4'b0001);
        chk("diag_lane0", out_data[31:0], 32'h3F80_0000);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk($sformatf("diag_vld%0d", k), out_valid, 4'b0001 << (k - 1));
            chk($sformatf("diag_busy%0d", k), busy, 1'b1);
        end
        chk("diag_lane3", out_data[127:96], 32'h4080_0000);
        tick();
        chk("diag_busy_fall", busy, 1'b0);

        // Eight rows back to back
        reset_pulse("rst1");
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = normal_row();
            tick();
        end
        in_valid = 1'b0;
        chk("b2b_cnt", row_cnt, 16'd8);
        repeat (N) tick();

        // Three-cycle stall in the middle of a stream
        in_valid = 1'b1;
        repeat (3) begin in_data = normal_row(); tick(); end
        stall = 1'b1;
        repeat (3) begin in_data = normal_row(); tick(); end
        stall = 1'b0;
        repeat (3) begin in_data = normal_row(); tick(); end
        in_valid = 1'b0;
        repeat (N + 1) tick();

        // Special-value screening and sticky flags
        reset_pulse("rst2");
        in_valid = 1'b1;
        in_data  = {32'h3F80_0000, 32'hFF80_0000, 32'h7F80_0001, 32'h0000_0001};
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        chk("spec_lane0", out_data[31:0], 32'h0000_0000);
        tick();
        chk("spec_lane1", out_data[63:32], 32'h7FC0_0000);
        tick();
        chk("spec_lane2", out_data[95:64], 32'hFF80_0000);
        repeat (3) tick();
        chk("spec_err_held", err, 2'b11);

        // Flush with three rows in flight
        in_valid = 1'b1;
        repeat (3) begin in_data = rand_row(); tick(); end
        flush = 1'b1;
        stall = 1'b1;
        tick();
        chk("flush_vld", out_valid, '0);
        chk("flush_busy", busy, 1'b0);
        chk("flush_cnt", row_cnt, '0);
        chk("flush_err", err, '0);
        flush = 1'b0;
        stall = 1'b0;
        repeat (2) begin in_data = rand_row(); tick(); end

        // Reset mid-stream with rows still being presented
        repeat (2) begin in_data = rand_row(); tick(); end
        reset_pulse("rst3");
        repeat (N + 2) begin in_data = rand_row(); tick(); end

        // Counter wrap on the narrow instance
        reset_pulse("rst4");
        in_valid = 1'b1;
        repeat (16) begin in_data = normal_row(); tick(); end
        in_valid = 1'b0;
        chk("wrap_cnt_w", row_cnt_w, 4'd0);
        chk("wrap_cnt", row_cnt, 16'd16);
        tick();

        // Random traffic with stalls, flushes and one reset
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 6) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            in_data  = rand_row();
            if (k == 200) reset_pulse("rst_rand");
            tick();
        end
        idle();
        repeat (N + 1) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
